// File: rtl/hps_uio_cmd_if.sv
// rtl/hps_uio_cmd_if.sv - UIO word bus and keyboard/mouse event stream bundle
interface hps_uio_cmd_if;
   logic        uio_ena;
   logic        io_strobe;
   logic [15:0] io_din;
   logic [15:0] io_dout;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_type;
   logic [7:0]  evt_data;

   // HPS / consumer side
   modport master (
      output uio_ena, io_strobe, io_din, evt_ready,
      input  io_dout, evt_valid, evt_type, evt_data
   );

   // decoder side
   modport slave (
      input  uio_ena, io_strobe, io_din, evt_ready,
      output io_dout, evt_valid, evt_type, evt_data
   );
endinterface

// File: rtl/hps_uio_cmd.sv
// rtl/hps_uio_cmd.sv - HPS user-IO command decoder with buffered input event FIFO
module hps_uio_cmd #(
   parameter int JOY_NUM   = 4,
   parameter int JOY_W     = 16,
   parameter int EVT_DEPTH = 8,
   parameter int STRLEN    = 0,
   parameter int STATUS_W  = 64
) (
   input  logic                                     clk_sys,
   input  logic                                     reset,
   hps_uio_cmd_if.slave                             uio,
   input  logic [(STRLEN > 0 ? 8*STRLEN : 8)-1:0]   conf_str,
   output logic [7:0]                               cfg,
   output logic [JOY_NUM*JOY_W-1:0]                 joy,
   output logic [STATUS_W-1:0]                      status,
   output logic                                     status_set,
   output logic [2:0]                               mouse_buttons,
   output logic                                     evt_ovf
);
   localparam int NSW    = STATUS_W / 16;
   localparam int AW     = $clog2(EVT_DEPTH);
   localparam int JOY_HI = JOY_W - 1;

   logic [9:0]                    cnt;
   logic [7:0]                    cmd;
   logic                          armed;
   logic                          ena_d;
   logic                          staged;
   logic                          set_pend;
   logic [NSW-1:0][15:0]          status_r;
   logic [NSW-1:0][15:0]          shadow;
   logic [JOY_NUM-1:0][JOY_W-1:0] joy_r;

   logic       strb;
   logic       word0;
   logic [2:0] joy_sel;
   logic       push;
   logic [9:0] push_data;
   logic       ovf_clr;

   logic [9:0] mem [EVT_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic       empty;
   logic       full;
   logic       pop;
   logic       push_ok;
   logic       push_drop;

   // a strobe only counts inside a frame that began after reset was released
   assign strb  = armed & uio.uio_ena & uio.io_strobe;
   assign word0 = (cnt == 10'd0);

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop       = ~empty & uio.evt_ready;
   assign push_ok   = push & (~full | pop);
   assign push_drop = push & full & ~pop;

   assign uio.evt_valid = ~empty;
   assign uio.evt_type  = mem[rptr[AW-1:0]][9:8];
   assign uio.evt_data  = mem[rptr[AW-1:0]][7:0];

   assign status = status_r;
   assign joy    = joy_r;

   // decode the current payload word into joystick select, event push and overflow clear
   always_comb begin
      joy_sel   = 3'd7;
      push      = 1'b0;
      push_data = '0;
      ovf_clr   = 1'b0;
      case (cmd)
         8'h02: joy_sel = 3'd0;
         8'h03: joy_sel = 3'd1;
         8'h10: joy_sel = 3'd2;
         8'h11: joy_sel = 3'd3;
         8'h12: joy_sel = 3'd4;
         8'h13: joy_sel = 3'd5;
         8'h04: begin
            push      = strb & ((cnt == 10'd1) | (cnt == 10'd2));
            push_data = {(cnt == 10'd2) ? 2'd1 : 2'd0, uio.io_din[7:0]};
         end
         8'h05: begin
            push      = strb & (cnt == 10'd1);
            push_data = {2'd2, uio.io_din[7:0]};
         end
         8'h06: begin
            push      = strb & (cnt == 10'd1);
            push_data = {2'd3, uio.io_din[7:0]};
         end
         8'h3A: ovf_clr = strb & (cnt == 10'd1);
         default: ;
      endcase
   end

   // framing, command execution, response word and status commit
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         cmd           <= '0;
         armed         <= 1'b0;
         ena_d         <= 1'b0;
         staged        <= 1'b0;
         set_pend      <= 1'b0;
         status_set    <= 1'b0;
         status_r      <= '0;
         shadow        <= '0;
         joy_r         <= '0;
         cfg           <= '0;
         mouse_buttons <= '0;
         evt_ovf       <= 1'b0;
         uio.io_dout   <= '0;
      end else begin
         ena_d      <= uio.uio_ena;
         set_pend   <= 1'b0;
         status_set <= set_pend;
         if (!uio.uio_ena) begin
            armed  <= 1'b1;
            cnt    <= '0;
            cmd    <= '0;
            staged <= 1'b0;
            if (ena_d && cmd == 8'h1E && staged) begin
               status_r <= shadow;
               set_pend <= 1'b1;
            end
         end else if (strb) begin
            if (cnt != 10'h3FF) cnt <= cnt + 10'd1;
            uio.io_dout <= '0;
            if (word0) begin
               cmd    <= uio.io_din[7:0];
               shadow <= status_r;
               staged <= 1'b0;
               if (uio.io_din[7:0] == 8'h2B) uio.io_dout <= 16'd1;
            end else begin
               case (cmd)
                  8'h01: cfg <= uio.io_din[7:0];
                  8'h04: if (cnt == 10'd3) mouse_buttons <= uio.io_din[2:0];
                  8'h14: for (int i = 0; i < STRLEN; i++)
                            if (cnt == 10'(i + 1)) uio.io_dout[7:0] <= conf_str[8*(STRLEN-1-i) +: 8];
                  8'h1E: for (int k = 0; k < NSW; k++)
                            if (cnt == 10'(k + 1)) begin
                               shadow[k] <= uio.io_din;
                               staged    <= 1'b1;
                            end
                  8'h1F: for (int k = 0; k < NSW; k++)
                            if (cnt == 10'(k + 1)) uio.io_dout <= status_r[k];
                  8'h3A: if (cnt == 10'd1) uio.io_dout <= {15'd0, evt_ovf};
                  default: ;
               endcase
               for (int j = 0; j < JOY_NUM; j++) begin
                  if (joy_sel == 3'(j)) begin
                     if (cnt == 10'd1) joy_r[j][15:0] <= uio.io_din;
                     if (JOY_W == 32 && cnt == 10'd2) joy_r[j][JOY_HI -: 16] <= uio.io_din;
                  end
               end
            end
         end
         if (push_drop)    evt_ovf <= 1'b1;
         else if (ovf_clr) evt_ovf <= 1'b0;
      end
   end

   // event FIFO pointers
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
      end
   end

   // event FIFO storage
   always_ff @(posedge clk_sys) begin
      if (push_ok) mem[wptr[AW-1:0]] <= push_data;
   end
endmodule

// File: tb/tb_hps_uio_cmd.sv
// tb/tb_hps_uio_cmd.sv - self-checking bench for hps_uio_cmd
module tb_hps_uio_cmd;
   localparam int JOY_NUM = 4, JOY_W = 32, EVT_DEPTH = 8, STRLEN = 3, STATUS_W = 64;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   hps_uio_cmd_if uio();
   logic [23:0]  conf_str = 24'h413B42;
   logic [7:0]   cfg;
   logic [127:0] joy;
   logic [63:0]  status;
   logic         status_set;
   logic [2:0]   mouse_buttons;
   logic         evt_ovf;

   hps_uio_cmd #(.JOY_NUM(JOY_NUM), .JOY_W(JOY_W), .EVT_DEPTH(EVT_DEPTH),
                 .STRLEN(STRLEN), .STATUS_W(STATUS_W)) dut (
      .clk_sys(clk_sys), .reset(reset), .uio(uio), .conf_str(conf_str), .cfg(cfg),
      .joy(joy), .status(status), .status_set(status_set),
      .mouse_buttons(mouse_buttons), .evt_ovf(evt_ovf)
   );

   int checks = 0, errors = 0;

   // reference model
   logic [9:0]   evq[$];
   logic         ovf_m;
   logic [63:0]  st_m;
   logic [127:0] joy_m;
   logic [2:0]   mb_m;
   logic [15:0]  resp;
   logic         valid_after;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic word(input logic [15:0] d);
      uio.io_din    = d;
      uio.io_strobe = 1'b1;
      tick();
      uio.io_strobe = 1'b0;
      resp        = uio.io_dout;
      valid_after = uio.evt_valid;
      tick();
   endtask

   task automatic frame_open();
      uio.uio_ena = 1'b1;
      tick();
   endtask

   task automatic frame_close();
      uio.uio_ena = 1'b0;
      tick();
      tick();
   endtask

   task automatic model_push(input logic [9:0] e);
      if (evq.size() < EVT_DEPTH) evq.push_back(e);
      else ovf_m = 1'b1;
   endtask

   task automatic drain(input string tag);
      uio.evt_ready = 1'b1;
      while (evq.size() > 0) begin
         check({tag, " valid"}, uio.evt_valid, 1'b1);
         check({tag, " head"}, {uio.evt_type, uio.evt_data}, evq.pop_front());
         tick();
      end
      uio.evt_ready = 1'b0;
      check({tag, " empty"}, uio.evt_valid, 1'b0);
   endtask

   initial begin
      uio.uio_ena   = 1'b0;
      uio.io_strobe = 1'b0;
      uio.io_din    = '0;
      uio.evt_ready = 1'b0;
      ovf_m = 1'b0; st_m = '0; joy_m = '0; mb_m = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // some state before a mid-transaction reset
      frame_open(); word(16'h01); word(16'h005A); frame_close();
      check("cfg_write", cfg, 8'h5A);
      frame_open(); word(16'h05); word(16'h0077); frame_close();
      check("pre_reset_valid", uio.evt_valid, 1'b1);
      frame_open(); word(16'h02); word(16'h7777);
      check("pre_reset_joy", joy[31:0], 32'h7777);
      reset = 1'b1;
      tick();
      check("rst_io_dout", uio.io_dout, 16'h0);
      check("rst_cfg", cfg, 8'h0);
      check("rst_joy", joy, 128'h0);
      check("rst_status", status, 64'h0);
      check("rst_mouse", mouse_buttons, 3'h0);
      check("rst_ovf", evt_ovf, 1'b0);
      check("rst_valid", uio.evt_valid, 1'b0);
      check("rst_status_set", status_set, 1'b0);
      reset = 1'b0;
      tick();
      // frame still open from before reset: must be ignored
      word(16'h1234);
      check("abandoned_frame", joy, 128'h0);
      frame_close();
      frame_open(); word(16'h02); word(16'h1234); frame_close();
      joy_m[31:0] = 32'h1234;
      check("joy0_16", joy, joy_m);

      // 32-bit joystick 3, joystick 5 out of range
      frame_open(); word(16'h11); word(16'hBEEF); word(16'hCAFE); frame_close();
      joy_m[3*32 +: 32] = 32'hCAFEBEEF;
      check("joy3_32", joy, joy_m);
      frame_open(); word(16'h13); word(16'h1111); word(16'h2222); frame_close();
      check("joy5_ignored", joy, joy_m);

      // unknown command
      frame_open(); word(16'h77); word(16'h1234);
      check("unknown_resp", resp, 16'h0);
      frame_close();

      // mouse frame, FIFO push visible the cycle after the strobe
      frame_open(); word(16'h04);
      check("mouse_pre_valid", uio.evt_valid, 1'b0);
      word(16'h0005);
      check("mouse_push_latency", valid_after, 1'b1);
      word(16'h00FB); word(16'h0003); frame_close();
      model_push({2'd0, 8'h05}); model_push({2'd1, 8'hFB}); mb_m = 3'd3;
      check("mouse_buttons", mouse_buttons, mb_m);
      drain("mouse");

      // overflow with ten keycodes
      for (int i = 0; i < 10; i++) begin
         frame_open(); word(16'h05); word(16'(i)); frame_close();
         model_push({2'd2, 8'(i)});
      end
      check("ovf_set", evt_ovf, ovf_m);
      frame_open(); word(16'h3A); word(16'h0);
      check("ovf_query", resp, {15'd0, ovf_m});
      ovf_m = 1'b0;
      check("ovf_cleared", evt_ovf, 1'b0);
      frame_close();
      drain("ovf");

      // full FIFO with push and pop in the same cycle
      for (int i = 0; i < EVT_DEPTH; i++) begin
         frame_open(); word(16'h06); word(16'h80 + 16'(i)); frame_close();
         model_push({2'd3, 8'h80 + 8'(i)});
      end
      frame_open(); word(16'h05);
      uio.io_din = 16'h0099; uio.io_strobe = 1'b1; uio.evt_ready = 1'b1;
      tick();
      uio.io_strobe = 1'b0; uio.evt_ready = 1'b0;
      void'(evq.pop_front());
      evq.push_back({2'd2, 8'h99});
      frame_close();
      check("full_pushpop_ovf", evt_ovf, 1'b0);
      drain("full_pushpop");

      // status write and readback
      frame_open(); word(16'h1E);
      for (int k = 0; k < 4; k++) word(16'hFFFF);
      frame_close();
      st_m = 64'hFFFF_FFFF_FFFF_FFFF;
      check("status_all", status, st_m);
      frame_open(); word(16'h1E); word(16'hAAAA); word(16'h5555);
      uio.uio_ena = 1'b0;
      tick();
      st_m[31:0] = 32'h5555_AAAA;
      check("status_partial", status, st_m);
      check("status_set_early", status_set, 1'b0);
      tick();
      check("status_set_pulse", status_set, 1'b1);
      tick();
      check("status_set_end", status_set, 1'b0);
      frame_open(); word(16'h1F);
      for (int k = 0; k < 5; k++) begin
         word(16'h0);
         check($sformatf("status_read%0d", k), resp, (k < 4) ? st_m[k*16 +: 16] : 16'h0);
      end
      frame_close();

      // conf string and 0x2B word-0 response
      frame_open(); word(16'h14);
      check("conf_word0", resp, 16'h0);
      for (int k = 0; k < 4; k++) begin
         word(16'h0);
         check($sformatf("conf_read%0d", k), resp, (k < STRLEN) ? 16'(conf_str[8*(STRLEN-1-k) +: 8]) : 16'h0);
      end
      frame_close();
      frame_open(); word(16'h2B);
      check("cmd2b_word0", resp, 16'h1);
      frame_close();

      // randomized event and status rounds
      for (int r = 0; r < 8; r++) begin
         int n;
         n = $urandom_range(0, 11);
         for (int e = 0; e < n; e++) begin
            int c;
            logic [7:0] d1, d2, d3;
            c  = $urandom_range(0, 2);
            d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            frame_open();
            if (c == 0) begin
               int nw;
               nw = $urandom_range(1, 3);
               word(16'h04);
               word({8'($urandom), d1}); model_push({2'd0, d1});
               if (nw > 1) begin word({8'h0, d2}); model_push({2'd1, d2}); end
               if (nw > 2) begin word({8'h0, d3}); mb_m = d3[2:0]; end
            end else begin
               word((c == 1) ? 16'h05 : 16'h06);
               word({8'($urandom), d1});
               model_push({(c == 1) ? 2'd2 : 2'd3, d1});
            end
            frame_close();
         end
         check($sformatf("rnd%0d_mouse", r), mouse_buttons, mb_m);
         check($sformatf("rnd%0d_ovf", r), evt_ovf, ovf_m);
         frame_open(); word(16'h3A); word(16'h0);
         check($sformatf("rnd%0d_ovf_query", r), resp, {15'd0, ovf_m});
         ovf_m = 1'b0;
         frame_close();
         drain($sformatf("rnd%0d", r));

         begin
            int nw;
            logic [15:0] w;
            nw = $urandom_range(1, 5);
            frame_open(); word(16'h1E);
            for (int k = 0; k < nw; k++) begin
               w = 16'($urandom);
               word(w);
               if (k < 4) st_m[k*16 +: 16] = w;
            end
            frame_close();
            check($sformatf("rnd%0d_status", r), status, st_m);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/hps_uio_cmd.md
Name: hps_uio_cmd

Overview:
- Parametrised successor of the Minimig HPS user-IO command decoder.
- Decodes the 16-bit UIO word stream from the HPS into joystick, config, status and conf-string traffic.
- Keyboard and mouse traffic goes into a buffered event FIFO with valid/ready handshake, so back-to-back events are no longer lost the way they are with a single toggle level.
- Sits between the HPS bus split logic and the core's input and OSD consumers.

Parameters:
- JOY_NUM, 4: number of joystick ports, 1..6.
- JOY_W, 16: joystick width, 16 or 32.
- EVT_DEPTH, 8: event FIFO depth, power of two, 2..64.
- STRLEN, 0: conf_str length in bytes.
- STATUS_W, 64: status register width, multiple of 16, 16..128.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- uio_ena  in  1  UIO transaction frame; low = idle.
- io_strobe  in  1  one-cycle word strobe, valid only while uio_ena=1.
- io_din  in  16  word from HPS.
- io_dout  out  16  registered response word to HPS.
- conf_str  in  8*STRLEN  configuration string, first char in the MSB byte.
- cfg  out  8  config byte.
- joy  out  JOY_NUM*JOY_W  joystick i occupies bits [i*JOY_W +: JOY_W].
- status  out  STATUS_W  status register.
- status_set  out  1  one-cycle pulse after a status write completes.
- mouse_buttons  out  3  mouse button state.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  consumer accepts the head.
- evt_type  out  2  0=mouse X, 1=mouse Y, 2=keycode, 3=OSD key.
- evt_data  out  8  event payload.
- evt_ovf  out  1  sticky overflow flag.

Behaviour:
Reset:
- io_dout, cfg, joy, status, mouse_buttons, evt_ovf = 0.
- status_set = 0.
- FIFO empty, evt_valid = 0.
- Command byte and word counter cleared.
- A reset mid-transaction abandons that transaction; decoding resumes at the next uio_ena rising frame.

Framing:
- uio_ena=0: cnt <= 0, cmd <= 0.
- On each io_strobe: cnt increments, saturating at 1023.
- Word 0 (cnt=0) latches cmd = io_din[7:0].
- Words cnt>=1 are the payload of cmd.
- Unknown cmd: payload ignored, io_dout=0.

io_dout timing:
- On every strobe, io_dout is first cleared to 0, then loaded with the response for that word.
- The HPS samples it on the following strobe, i.e. one-word latency.
- Word-0 responses: cmd 0x2B -> 1; all other commands -> 0.

Commands:
- 0x01: cfg <= io_din[7:0] on every payload word.
- Joysticks: 0x02, 0x03, 0x10, 0x11, 0x12, 0x13 select joystick 0..5.
  - Command index >= JOY_NUM: ignored.
  - cnt=1 writes bits [15:0].
  - cnt=2 writes bits [31:16], only when JOY_W=32.
- 0x04 mouse:
  - cnt=1: push {0, io_din[7:0]}.
  - cnt=2: push {1, io_din[7:0]}.
  - cnt=3: mouse_buttons <= io_din[2:0], no push.
- 0x05: cnt=1 pushes {2, io_din[7:0]}.
- 0x06: cnt=1 pushes {3, io_din[7:0]}.
- 0x14 conf string: for 1 <= cnt <= STRLEN, io_dout[7:0] <= conf_str byte (cnt-1) counted from the MSB. Beyond STRLEN: 0.
- 0x1E status write:
  - Payload word k (cnt=k, 1 <= k <= STATUS_W/16) is staged into shadow bits [(k-1)*16 +: 16].
  - Words beyond STATUS_W/16 are ignored.
  - On uio_ena falling with cmd=0x1E and at least one word staged, status <= shadow.
  - status_set pulses one cycle later.
  - Unwritten words keep their previous status value (the shadow is preloaded from status at word 0).
- 0x1F status read: cnt=k returns status word k-1 for 1 <= k <= STATUS_W/16; 0 beyond.
- 0x3A overflow query: cnt=1 returns {15'd0, evt_ovf}; evt_ovf is cleared on that strobe.

Event FIFO:
- Circular buffer of EVT_DEPTH x 10 bits with registered read/write pointers one bit wider than the address.
- Head outputs are driven directly from the buffer at the read pointer.
- Pop when evt_valid & evt_ready.
- Push while full with no pop in the same cycle: entry dropped, evt_ovf <= 1. An overflow set takes priority over a 0x3A clear in the same cycle.
- Push while full with a pop in the same cycle: accepted; occupancy unchanged.
- Empty: evt_valid=0, and a push appears on evt_valid the cycle after the strobe. No same-cycle bypass.
- Order is strictly FIFO across all event types.

Test Plan:
- Reset asserted mid-0x02 transfer -> all outputs 0 and evt_valid=0; after release, frame 0x02,0x1234 -> joy[15:0]=0x1234.
- JOY_W=32, JOY_NUM=4: frame 0x11,0xBEEF,0xCAFE -> joystick 3 = 0xCAFEBEEF; frame 0x13 -> joy unchanged.
- Frame 0x04,0x05,0xFB,0x03 with evt_ready=0 -> FIFO holds {0,0x05},{1,0xFB}; mouse_buttons=3; raising evt_ready pops in that order.
- EVT_DEPTH=8, evt_ready=0, ten 0x05 frames (data 0..9) -> first 8 retained, evt_ovf=1; frame 0x3A returns 1 then evt_ovf=0.
- Frame 0x1E,0xAAAA,0x5555 with STATUS_W=64, status previously 0xFFFF_FFFF_FFFF_FFFF -> status=0xFFFF_FFFF_5555_AAAA, one status_set pulse after uio_ena falls; 0x1F readback returns 0xAAAA, 0x5555, 0xFFFF, 0xFFFF.
- STRLEN=3, conf_str="A;B", frame 0x14 with 4 reads -> io_dout sequence 0x41, 0x3B, 0x42, 0x00; word-0 of 0x2B -> 0x0001.
